// File: rtl/wdma_buf_sched.sv
// wdma_buf_sched: host buffer address queue and issue scheduler for the write DMA.
// Host address pairs are queued in a DEPTH-entry circular buffer. A request from the
// write-DMA sequencer pops the head and presents it one cycle later as a registered strobe.
// Optional feature macro: WDMA_BUF_RECYCLE_EN. When it is defined, popped entries are
// written back at the tail, so the queue replays as a ring.
module wdma_buf_sched #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_rst_i,
    input  logic [31:0] next_wdma_addr_i,
    input  logic [7:0]  next_wdma_up_addr_i,
    input  logic        next_wdma_valid_i,
    input  logic        buf_req_i,
    output logic [63:0] buf_addr_o,
    output logic        buf_valid_o,
    output logic        buf_empty_o,
    output logic        buf_full_o,
    output logic [4:0]  buf_level_o,
    output logic [6:0]  buf_ptr_o,
    output logic [7:0]  ovf_cnt_o,
    output logic        unf_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StPend, StIssue} state_e;

    state_e          state_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW-1:0]   rd_ptr_d, wr_ptr_d;
    logic [4:0]      level_q, level_d;
    logic [39:0]     mem_q [DEPTH];
    logic [39:0]     head;
    logic [39:0]     new_entry;
    logic            full, nonempty;
    logic            pop, push_ok, drop;
`ifdef WDMA_BUF_RECYCLE_EN
    logic [AW-1:0]   push_idx;
`endif

    assign head      = mem_q[rd_ptr_q];
    assign new_entry = {next_wdma_up_addr_i, next_wdma_addr_i};
    assign full      = (level_q == 5'(DEPTH));
    assign nonempty  = (level_q != 5'd0);

    assign buf_level_o = level_q;
    assign buf_empty_o = ~nonempty;
    assign buf_full_o  = full;

    // Pop/push decisions; a soft flush suppresses both.
    always_comb begin
        pop      = 1'b0;
        push_ok  = 1'b0;
        drop     = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
`ifdef WDMA_BUF_RECYCLE_EN
        push_idx = wr_ptr_q;
`endif
        if (!init_rst_i) begin
            // PEND leaves as soon as an entry is stored; requests there are ignored.
            if (nonempty) begin
                pop = ((state_q == StIdle) && buf_req_i) || (state_q == StPend);
            end
`ifdef WDMA_BUF_RECYCLE_EN
            // The recycled entry takes the tail slot, so host pushes need real free space.
            push_ok  = next_wdma_valid_i && !full;
            push_idx = wr_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(pop) + AW'(push_ok);
            level_d  = level_q + 5'(push_ok);
`else
            // When full, a coincident pop frees the slot the push lands in.
            push_ok  = next_wdma_valid_i && (!full || pop);
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            level_d  = level_q + 5'(push_ok) - 5'(pop);
`endif
            drop     = next_wdma_valid_i && !push_ok;
            rd_ptr_d = rd_ptr_q + AW'(pop);
        end
    end

    // Entry storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
`ifdef WDMA_BUF_RECYCLE_EN
        if (pop) begin
            mem_q[wr_ptr_q] <= head;
        end
        if (push_ok) begin
            mem_q[push_idx] <= new_entry;
        end
`else
        if (push_ok) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
`endif
    end

    // Issue FSM with pointers, level and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= 5'd0;
            buf_valid_o <= 1'b0;
            buf_addr_o  <= 64'd0;
            buf_ptr_o   <= 7'd0;
            ovf_cnt_o   <= 8'd0;
            unf_o       <= 1'b0;
        end else if (init_rst_i) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= 5'd0;
            buf_valid_o <= 1'b0;
            buf_addr_o  <= 64'd0;
            buf_ptr_o   <= 7'd0;
            ovf_cnt_o   <= 8'd0;
            unf_o       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            buf_valid_o <= pop;
            if (pop) begin
                buf_addr_o <= {24'h0, head};
                buf_ptr_o  <= buf_ptr_o + 7'd1;
            end
            if (drop && (ovf_cnt_o != 8'hff)) begin
                ovf_cnt_o <= ovf_cnt_o + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (buf_req_i) begin
                        if (nonempty) begin
                            state_q <= StIssue;
                        end else begin
                            state_q <= StPend;
                            unf_o   <= 1'b1;
                        end
                    end
                end
                StPend: begin
                    if (nonempty) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wdma_buf_sched.sv
// tb_wdma_buf_sched: directed and randomized checks of wdma_buf_sched against a
// queue-based reference model of the issue rules.
module tb_wdma_buf_sched;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_rst_i;
    logic [31:0] next_wdma_addr_i;
    logic [7:0]  next_wdma_up_addr_i;
    logic        next_wdma_valid_i;
    logic        buf_req_i;
    logic [63:0] buf_addr_o;
    logic        buf_valid_o;
    logic        buf_empty_o;
    logic        buf_full_o;
    logic [4:0]  buf_level_o;
    logic [6:0]  buf_ptr_o;
    logic [7:0]  ovf_cnt_o;
    logic        unf_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [39:0] mq[$];
    bit        m_wait;
    bit        m_issue;
    bit        m_valid;
    bit [63:0] m_addr;
    int        m_ptr;
    int        m_ovf;
    bit        m_unf;

    wdma_buf_sched #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_rst_i          (init_rst_i),
        .next_wdma_addr_i    (next_wdma_addr_i),
        .next_wdma_up_addr_i (next_wdma_up_addr_i),
        .next_wdma_valid_i   (next_wdma_valid_i),
        .buf_req_i           (buf_req_i),
        .buf_addr_o          (buf_addr_o),
        .buf_valid_o         (buf_valid_o),
        .buf_empty_o         (buf_empty_o),
        .buf_full_o          (buf_full_o),
        .buf_level_o         (buf_level_o),
        .buf_ptr_o           (buf_ptr_o),
        .ovf_cnt_o           (ovf_cnt_o),
        .unf_o               (unf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        m_wait  = 1'b0;
        m_issue = 1'b0;
        m_valid = 1'b0;
        m_addr  = 64'd0;
        m_ptr   = 0;
        m_ovf   = 0;
        m_unf   = 1'b0;
    endfunction

    // One clock of the scheduler, expressed as queue operations.
    function automatic void model_step(input bit v, input bit [39:0] d, input bit r, input bit ini);
        bit        pop;
        bit        acc;
        int        sz;
        bit [39:0] popped;
        if (ini) begin
            model_clear();
            return;
        end
        sz  = mq.size();
        pop = !m_issue && (sz > 0) && (m_wait || r);
`ifdef WDMA_BUF_RECYCLE_EN
        acc = v && (sz < DEPTH);
`else
        acc = v && ((sz < DEPTH) || pop);
`endif
        m_valid = pop;
        if (pop) begin
            popped = mq.pop_front();
            m_addr = {24'h0, popped};
            m_ptr  = (m_ptr + 1) % 128;
`ifdef WDMA_BUF_RECYCLE_EN
            mq.push_back(popped);
`endif
        end
        if (acc) mq.push_back(d);
        else if (v && m_ovf < 255) m_ovf++;
        if (pop) m_wait = 1'b0;
        else if (!m_issue && !m_wait && r && sz == 0) begin
            m_wait = 1'b1;
            m_unf  = 1'b1;
        end
        m_issue = pop;
    endfunction

    task automatic check_all();
        chk("valid", 64'(buf_valid_o), 64'(m_valid));
        chk("addr",  buf_addr_o,       m_addr);
        chk("ptr",   64'(buf_ptr_o),   64'(m_ptr));
        chk("ovf",   64'(ovf_cnt_o),   64'(m_ovf));
        chk("unf",   64'(unf_o),       64'(m_unf));
        chk("level", 64'(buf_level_o), 64'(mq.size()));
        chk("empty", 64'(buf_empty_o), 64'(mq.size() == 0));
        chk("full",  64'(buf_full_o),  64'(mq.size() == DEPTH));
    endtask

    task automatic step(input bit v, input bit [39:0] d, input bit r, input bit ini);
        @(negedge clk);
        next_wdma_valid_i   = v;
        next_wdma_addr_i    = d[31:0];
        next_wdma_up_addr_i = d[39:32];
        buf_req_i           = r;
        init_rst_i          = ini;
        model_step(v, d, r, ini);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 40'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bit [39:0] d;
        bit        v, r, ini;
        rst = 1'b1;
        init_rst_i = 1'b0;
        next_wdma_addr_i = 32'd0;
        next_wdma_up_addr_i = 8'd0;
        next_wdma_valid_i = 1'b0;
        buf_req_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

`ifndef WDMA_BUF_RECYCLE_EN
        // Single push, request long after
        step(1'b1, 40'h00_8000_0000, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 40'd0, 1'b1, 1'b0);
        chk("r035_valid", 64'(buf_valid_o), 64'd1);
        chk("r035_addr",  buf_addr_o, 64'h0000_0000_8000_0000);
        chk("r035_ptr",   64'(buf_ptr_o), 64'd1);
        chk("r035_level", 64'(buf_level_o), 64'd0);
        idle(2);

        // Request on empty queue, push later
        step(1'b0, 40'd0, 1'b1, 1'b0);
        chk("r036_unf", 64'(unf_o), 64'd1);
        idle(10);
        step(1'b1, 40'h0A_1234_5678, 1'b0, 1'b0);
        chk("r036_nobypass", 64'(buf_valid_o), 64'd0);
        idle(1);
        chk("r036_valid", 64'(buf_valid_o), 64'd1);
        chk("r036_addr",  buf_addr_o, 64'h0000_000A_1234_5678);
        idle(2);

        // Overfill, then drain in FIFO order
        for (int i = 0; i < DEPTH + 3; i++) step(1'b1, {8'(i), 32'h1000_0000 + i}, 1'b0, 1'b0);
        chk("r037_full",  64'(buf_full_o), 64'd1);
        chk("r037_ovf",   64'(ovf_cnt_o), 64'd3);
        chk("r037_level", 64'(buf_level_o), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 40'd0, 1'b1, 1'b0);
            chk("r037_order", buf_addr_o, {24'h0, 8'(i), 32'h1000_0000 + i});
            idle(1);
        end

        // Full queue, push and request together
        for (int i = 0; i < DEPTH; i++) step(1'b1, {8'h20, 32'h2000_0000 + i}, 1'b0, 1'b0);
        step(1'b1, 40'h55_AAAA_5555, 1'b1, 1'b0);
        chk("r038_level", 64'(buf_level_o), 64'(DEPTH));
        chk("r038_ovf",   64'(ovf_cnt_o), 64'd3);
        chk("r038_valid", 64'(buf_valid_o), 64'd1);
        idle(1);

        // Soft flush racing a request
        step(1'b0, 40'd0, 1'b1, 1'b1);
        chk("r039_valid", 64'(buf_valid_o), 64'd0);
        chk("r039_ptr",   64'(buf_ptr_o), 64'd0);
        chk("r039_ovf",   64'(ovf_cnt_o), 64'd0);
        chk("r039_unf",   64'(unf_o), 64'd0);
        chk("r039_empty", 64'(buf_empty_o), 64'd1);
        chk("r039_level", 64'(buf_level_o), 64'd0);
        idle(2);
`else
        // Ring replay of three entries
        step(1'b1, 40'h01_AAAA_0001, 1'b0, 1'b0);
        step(1'b1, 40'h02_BBBB_0002, 1'b0, 1'b0);
        step(1'b1, 40'h03_CCCC_0003, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 40'd0, 1'b1, 1'b0);
            case (i % 3)
                0: chk("r040_addr", buf_addr_o, 64'h0000_0001_AAAA_0001);
                1: chk("r040_addr", buf_addr_o, 64'h0000_0002_BBBB_0002);
                default: chk("r040_addr", buf_addr_o, 64'h0000_0003_CCCC_0003);
            endcase
            chk("r040_level", 64'(buf_level_o), 64'd3);
            idle(1);
        end
        chk("r040_ptr", 64'(buf_ptr_o), 64'd7);
        step(1'b0, 40'd0, 1'b0, 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 99) < 45);
            r   = ($urandom_range(0, 99) < 30);
            ini = ($urandom_range(0, 99) < 2);
            d   = {8'($urandom), 32'($urandom)};
            step(v, d, r, ini);
        end

        // Asynchronous reset in the middle of a cycle
        step(1'b1, 40'h77_1111_2222, 1'b1, 1'b0);
        @(negedge clk);
        next_wdma_valid_i = 1'b0;
        buf_req_i = 1'b0;
        init_rst_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
